fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the byte address fetched after reset or restart.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port restart  input  1  single-cycle pulse forcing the fetch stream back to RESET_PC.
REQ-005 SHALL have port stall  input  1  the downstream stage cannot accept the delivered instruction.
REQ-006 SHALL have port branch_taken  input  1  the delivered instruction is a taken branch.
REQ-007 SHALL have port branch_offset  input  16  signed word offset of the branch.
REQ-008 SHALL have port jump  input  1  the delivered instruction is J or JAL.
REQ-009 SHALL have port jump_target  input  26  J-format word index.
REQ-010 SHALL have port jr  input  1  the delivered instruction is JR or JALR.
REQ-011 SHALL have port jr_target  input  32  register byte address.
REQ-012 SHALL have port imem_req  output  1  fetch request.
REQ-013 SHALL have port imem_addr  output  32  fetch byte address.
REQ-014 SHALL have port imem_ready  input  1  memory returns imem_rdata in this cycle.
REQ-015 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-016 SHALL have port instr_valid  output  1  instr and instr_pc hold a deliverable instruction.
REQ-017 SHALL have port instr  output  32  delivered instruction.
REQ-018 SHALL have port instr_pc  output  32  byte address of instr.

Function
REQ-019 SHALL implement the states IDLE, FETCH, DELIVER and DRAIN.
REQ-020 IDLE SHALL drive imem_req=0 and SHALL go to FETCH in the next cycle unconditionally.
REQ-021 FETCH SHALL drive imem_req=1, and imem_addr SHALL stay stable until imem_ready; on ready it SHALL latch instr<=imem_rdata and instr_pc<=imem_addr, and move to DELIVER.
REQ-022 DELIVER SHALL drive instr_valid=1 and imem_req=0; instr_valid SHALL first rise in the cycle after imem_ready.
REQ-023 DELIVER with stall=1 SHALL hold instr, instr_pc and instr_valid unchanged, and SHALL ignore the redirect inputs.
REQ-024 DELIVER with stall=0 SHALL consume the instruction, compute next address, and go to FETCH; the new request SHALL appear the following cycle.
REQ-025 Next-address priority SHALL be: jr -> jr_target; else jump -> {instr_pc+4 [31:28], jump_target, 2'b00}; else branch_taken -> instr_pc+4+(sign-extended branch_offset<<2); else instr_pc+4.
REQ-026 All address arithmetic SHALL be 32-bit modulo 2^32, with silent wrap at 32'hFFFF_FFFC.
REQ-027 With zero-wait memory, throughput SHALL be one instruction per 2 cycles (FETCH, DELIVER).
REQ-028 restart in IDLE SHALL have no additional effect.
REQ-029 restart in FETCH with imem_ready=0 SHALL go to DRAIN, keep imem_req and imem_addr stable, and record RESET_PC as pending.
REQ-030 restart in FETCH with imem_ready=1 SHALL discard imem_rdata, keep instr_valid=0, and go to FETCH at RESET_PC.
REQ-031 DRAIN SHALL hold the request until imem_ready, discard that data, then go to FETCH at RESET_PC; a further restart in DRAIN SHALL change nothing.
REQ-032 restart in DELIVER SHALL override stall and redirects, drop instr_valid the next cycle, and go to FETCH at RESET_PC.
REQ-033 Redirect inputs SHALL be sampled only in DELIVER with stall=0.

Reset
REQ-034 On reset the block SHALL set state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, clear any pending restart, and take effect immediately without waiting for clk.
REQ-035 Reset asserted mid-fetch SHALL abandon the request with no drain; the memory side tolerates a withdrawn request.

Structure
REQ-036 The state encoding, RESET_PC default and the increment constant 4 SHALL live in the shared processor package.
REQ-037 Branch offset extension SHALL use the existing sign_exten sub-module; no other sub-modules.

Verification
REQ-038 Reset release, imem_ready tied 1, no redirects -> imem_addr 0,4,8,C on alternate cycles; instr_pc matches.
REQ-039 Instr at 0x100 delivered with branch_taken, offset 16'hFFFE -> next imem_addr 0x0FC; jr=1 in the same cycle with jr_target 0x400 -> 0x400.
REQ-040 Jump at 0xF000_0010, jump_target 26'h0000040 -> next imem_addr 0xF000_0100.
REQ-041 stall held 3 cycles in DELIVER -> instr and instr_valid constant, imem_req 0, redirect asserted during stall ignored.
REQ-042 restart while FETCH waits (ready delayed 3 cycles) -> imem_addr stable, returned word never on instr_valid, next request at RESET_PC.
REQ-043 Reset asserted mid-FETCH -> imem_req=0 and imem_addr=RESET_PC before the next clk edge.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared processor definitions for the fetch sequencer: widths, reset PC,
// the PC increment, the sequencer state encoding and the delivered-instruction payload.
package fetch_sequencer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OFF_W = 16;
    localparam int unsigned JT_W  = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2,
        DRAIN   = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_out_t;

endpackage

// File: rtl/sign_exten.sv
// Sign extension of a narrow immediate to the full datapath width.
module sign_exten #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  value_i,
    output logic [OUT_W-1:0] ext_c_o
);

    assign ext_c_o = {{(OUT_W - IN_W){value_i[IN_W-1]}}, value_i};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one fetch at a time, holds the returned word
// until the downstream stage consumes it, then redirects or advances the PC.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic             jump,
    input  logic [JT_W-1:0]  jump_target,
    input  logic             jr,
    input  logic [XLEN-1:0]  jr_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_pc
);

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] addr_q, addr_d;
    fetch_out_t      out_q, out_d;

    logic [XLEN-1:0] off_ext_c;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] next_pc_c;

    sign_exten #(
        .IN_W  (OFF_W),
        .OUT_W (XLEN)
    ) u_sign_exten (
        .value_i (branch_offset),
        .ext_c_o (off_ext_c)
    );

    // Redirect priority: register jump, then J-format jump, then branch, then sequential
    always_comb begin
        pc_plus4_c = out_q.pc + PC_INC;
        next_pc_c  = pc_plus4_c;
        if (jr) begin
            next_pc_c = jr_target;
        end else if (jump) begin
            next_pc_c = {pc_plus4_c[XLEN-1:XLEN-4], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc_c = pc_plus4_c + {off_ext_c[XLEN-3:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (restart) begin
                    // Outstanding request must complete before refetching from RESET_PC
                    if (imem_ready) begin
                        addr_d = RESET_PC;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    state_d   = DELIVER;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    out_d.instr = imem_rdata;
                    out_d.pc    = addr_q;
                end
            end
            DELIVER: begin
                if (restart) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    addr_d  = RESET_PC;
                end else if (!stall) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    addr_d  = next_pc_c;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    state_d = FETCH;
                    addr_d  = RESET_PC;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
                addr_d  = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = out_q.instr;
    assign instr_pc    = out_q.pc;

endmodule
